// File: rtl/mem_stack_sequencer_if.sv
// EX->MEM control and data-memory port bundle for mem_stack_sequencer.
// Optional stack_err_out exists only when STACK_BOUNDS_CHECK_EN is defined.
interface mem_stack_sequencer_if #(
   parameter int unsigned ADDR_W = 11
);
   logic              mem_write_in;
   logic              mem_read_in;
   logic              mem_type_in;
   logic [1:0]        SP_src_in;
   logic              mem_addr_src_in;
   logic              mem_data_src_in;
   logic              PC_push_pop_in;
   logic              flags_push_pop_in;
   logic [31:0]       PC_in;
   logic [15:0]       alu_result_in;
   logic [15:0]       Rsrc_val_in;
   logic [15:0]       Rdst_val_in;
   logic [15:0]       mem_rdata_in;

   logic [ADDR_W-1:0] mem_addr_out;
   logic [15:0]       mem_wdata_out;
   logic              mem_we_out;
   logic              mem_re_out;
   logic [15:0]       load_data_out;
   logic              load_valid_out;
   logic              stall_out;
   logic              pc_load_out;
   logic [31:0]       pc_pop_out;
   logic              is_POP_flags_out;
   logic [2:0]        POP_flags_val_out;
   logic [ADDR_W-1:0] SP_out;
`ifdef STACK_BOUNDS_CHECK_EN
   logic              stack_err_out;
`endif

   // Pipeline/memory side: drives requests and read data
   modport master (
      output mem_write_in, mem_read_in, mem_type_in, SP_src_in,
             mem_addr_src_in, mem_data_src_in, PC_push_pop_in, flags_push_pop_in,
             PC_in, alu_result_in, Rsrc_val_in, Rdst_val_in, mem_rdata_in,
      input  mem_addr_out, mem_wdata_out, mem_we_out, mem_re_out,
             load_data_out, load_valid_out, stall_out, pc_load_out,
             pc_pop_out, is_POP_flags_out, POP_flags_val_out, SP_out
`ifdef STACK_BOUNDS_CHECK_EN
      , input stack_err_out
`endif
   );

   // Sequencer side
   modport slave (
      input  mem_write_in, mem_read_in, mem_type_in, SP_src_in,
             mem_addr_src_in, mem_data_src_in, PC_push_pop_in, flags_push_pop_in,
             PC_in, alu_result_in, Rsrc_val_in, Rdst_val_in, mem_rdata_in,
      output mem_addr_out, mem_wdata_out, mem_we_out, mem_re_out,
             load_data_out, load_valid_out, stall_out, pc_load_out,
             pc_pop_out, is_POP_flags_out, POP_flags_val_out, SP_out
`ifdef STACK_BOUNDS_CHECK_EN
      , output stack_err_out
`endif
   );
endinterface

// File: rtl/mem_stack_sequencer.sv
// Memory-stage stack pointer owner and 16/32-bit data-memory access sequencer.
// Define STACK_BOUNDS_CHECK_EN to add the sticky stack_err_out bounds check.
module mem_stack_sequencer #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned SP_RESET = 2046
) (
   input logic                  clk,
   input logic                  reset,
   mem_stack_sequencer_if.slave bus
);

`ifdef STACK_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH2   = 3'd1,
      POP2    = 3'd2,
      POPDONE = 3'd3,
      LDWAIT  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] sp, sp_nxt;
   logic [15:0]       low_q, low_nxt;
   logic              err_q, err_nxt;

   logic              wr_req, rd_req, push_req, pop_req, dword;
   logic              push_bad, pop_bad;
   logic [ADDR_W-1:0] sp_inc, sp_dec, addr_sel;
   logic [15:0]       data_sel, pc_high;

   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_we, mem_re;
   logic [15:0]       load_data;
   logic              load_valid, stall, pc_load, pop_flags;
   logic [31:0]       pc_pop;
   logic [2:0]        flags_val;

   // Request decode; write wins over read, reserved SP_src behaves as no SP use
   always_comb begin
      wr_req   = bus.mem_write_in;
      rd_req   = bus.mem_read_in & ~bus.mem_write_in;
      push_req = wr_req & (bus.SP_src_in == 2'b01);
      pop_req  = rd_req & (bus.SP_src_in == 2'b10);
      dword    = bus.mem_type_in | bus.PC_push_pop_in;
      sp_inc   = sp + ADDR_W'(1);
      sp_dec   = sp - ADDR_W'(1);
      addr_sel = bus.mem_addr_src_in ? ADDR_W'(bus.Rsrc_val_in) : ADDR_W'(bus.alu_result_in);
      data_sel = bus.mem_data_src_in ? bus.Rdst_val_in : bus.Rsrc_val_in;
      pc_high  = {(bus.flags_push_pop_in ? bus.PC_in[31:29] : 3'b000), bus.PC_in[28:16]};
      push_bad = BOUNDS_EN & (sp == '0);
      pop_bad  = BOUNDS_EN & (sp == ADDR_W'(SP_RESET));
   end

   // Next state, SP update and per-cycle memory/pipeline outputs
   always_comb begin
      state_nxt  = state;
      sp_nxt     = sp;
      low_nxt    = low_q;
      err_nxt    = err_q;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      load_data  = '0;
      load_valid = 1'b0;
      stall      = 1'b0;
      pc_load    = 1'b0;
      pc_pop     = '0;
      pop_flags  = 1'b0;
      flags_val  = '0;

      if (!reset) begin
         unique case (state)
            IDLE: begin
               if (push_req) begin
                  if (push_bad) begin
                     err_nxt = 1'b1;
                  end else begin
                     mem_we   = 1'b1;
                     mem_addr = sp;
                     sp_nxt   = sp_dec;
                     if (dword) begin
                        mem_wdata = pc_high;
                        stall     = 1'b1;
                        state_nxt = PUSH2;
                     end else begin
                        mem_wdata = data_sel;
                     end
                  end
               end else if (pop_req) begin
                  if (pop_bad) begin
                     err_nxt = 1'b1;
                  end else begin
                     mem_re    = 1'b1;
                     mem_addr  = sp_inc;
                     sp_nxt    = sp_inc;
                     stall     = 1'b1;
                     state_nxt = dword ? POP2 : LDWAIT;
                  end
               end else if (wr_req) begin
                  mem_we    = 1'b1;
                  mem_addr  = addr_sel;
                  mem_wdata = data_sel;
               end else if (rd_req) begin
                  mem_re    = 1'b1;
                  mem_addr  = addr_sel;
                  stall     = 1'b1;
                  state_nxt = LDWAIT;
               end
            end
            PUSH2: begin
               // PC_in is still the same instruction, held by last cycle's stall
               state_nxt = IDLE;
               if (push_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_addr  = sp;
                  mem_wdata = bus.PC_in[15:0];
                  sp_nxt    = sp_dec;
               end
            end
            POP2: begin
               if (pop_bad) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  low_nxt   = bus.mem_rdata_in;
                  mem_re    = 1'b1;
                  mem_addr  = sp_inc;
                  sp_nxt    = sp_inc;
                  stall     = 1'b1;
                  state_nxt = POPDONE;
               end
            end
            POPDONE: begin
               state_nxt = IDLE;
               pc_load   = 1'b1;
               pc_pop    = {3'b000, bus.mem_rdata_in[12:0], low_q};
               if (bus.flags_push_pop_in) begin
                  pop_flags = 1'b1;
                  flags_val = bus.mem_rdata_in[15:13];
               end
            end
            LDWAIT: begin
               state_nxt  = IDLE;
               load_data  = bus.mem_rdata_in;
               load_valid = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, stack pointer, captured low word and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sp    <= ADDR_W'(SP_RESET);
         low_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         sp    <= sp_nxt;
         low_q <= low_nxt;
         err_q <= err_nxt;
      end
   end

   assign bus.mem_addr_out      = mem_addr;
   assign bus.mem_wdata_out     = mem_wdata;
   assign bus.mem_we_out        = mem_we;
   assign bus.mem_re_out        = mem_re;
   assign bus.load_data_out     = load_data;
   assign bus.load_valid_out    = load_valid;
   assign bus.stall_out         = stall;
   assign bus.pc_load_out       = pc_load;
   assign bus.pc_pop_out        = pc_pop;
   assign bus.is_POP_flags_out  = pop_flags;
   assign bus.POP_flags_val_out = flags_val;
   assign bus.SP_out            = sp;

`ifdef STACK_BOUNDS_CHECK_EN
   assign bus.stack_err_out = err_q;
`else
   logic unused_err;
   assign unused_err = err_q;
`endif

   // Only the low ADDR_W bits of the ALU result form an address
   logic unused_alu;
   assign unused_alu = ^bus.alu_result_in;

endmodule

// File: tb/tb_mem_stack_sequencer.sv
// Directed self-checking bench for mem_stack_sequencer with a behavioural
// synchronous word memory; covers STACK_BOUNDS_CHECK_EN both ways.
module tb_mem_stack_sequencer;
   localparam int unsigned ADDR_W = 11;

   logic clk = 1'b0;
   logic reset;
   int   n_checks;
   int   n_errors;

   always #5 clk = ~clk;

   mem_stack_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   mem_stack_sequencer #(.ADDR_W(ADDR_W), .SP_RESET(2046)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] tb_mem [0:2047];

   // Synchronous data memory: read data valid the cycle after re
   always @(posedge clk) begin
      if (bus.mem_we_out) tb_mem[bus.mem_addr_out] <= bus.mem_wdata_out;
      if (bus.mem_re_out) bus.mem_rdata_in <= tb_mem[bus.mem_addr_out];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {we, re, stall, load_valid, pc_load, is_POP_flags}
   function automatic logic [5:0] strb();
      return {bus.mem_we_out, bus.mem_re_out, bus.stall_out,
              bus.load_valid_out, bus.pc_load_out, bus.is_POP_flags_out};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clr();
      bus.mem_write_in      = 1'b0;
      bus.mem_read_in       = 1'b0;
      bus.mem_type_in       = 1'b0;
      bus.SP_src_in         = 2'b00;
      bus.mem_addr_src_in   = 1'b0;
      bus.mem_data_src_in   = 1'b0;
      bus.PC_push_pop_in    = 1'b0;
      bus.flags_push_pop_in = 1'b0;
      bus.PC_in             = '0;
      bus.alu_result_in     = '0;
      bus.Rsrc_val_in       = '0;
      bus.Rdst_val_in       = '0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      clr();
      cyc();
      cyc();
      mid();
      check("rst_strb", 32'(strb()), 32'h0);
      check("rst_sp", 32'(bus.SP_out), 32'd2046);
      check("rst_pcpop", bus.pc_pop_out, 32'h0);
`ifdef STACK_BOUNDS_CHECK_EN
      check("rst_err", 32'(bus.stack_err_out), 32'h0);
`endif
      cyc();
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         mid();
         check("idle_sp", 32'(bus.SP_out), 32'd2046);
         check("idle_strb", 32'(strb()), 32'h0);
         cyc();
      end

      // 16-bit push of Rsrc
      bus.mem_write_in = 1'b1; bus.SP_src_in = 2'b01; bus.Rsrc_val_in = 16'h1234;
      mid();
      check("push16_strb", 32'(strb()), 32'(6'b100000));
      check("push16_addr", 32'(bus.mem_addr_out), 32'd2046);
      check("push16_wdata", 32'(bus.mem_wdata_out), 32'h1234);
      cyc(); clr();
      mid();
      check("push16_sp", 32'(bus.SP_out), 32'd2045);
      check("push16_mem", 32'(tb_mem[2046]), 32'h1234);
      cyc();

      // 16-bit pop
      bus.mem_read_in = 1'b1; bus.SP_src_in = 2'b10;
      mid();
      check("pop16_strb", 32'(strb()), 32'(6'b011000));
      check("pop16_addr", 32'(bus.mem_addr_out), 32'd2046);
      cyc();
      mid();
      check("pop16_wait_strb", 32'(strb()), 32'(6'b000100));
      check("pop16_data", 32'(bus.load_data_out), 32'h1234);
      check("pop16_sp", 32'(bus.SP_out), 32'd2046);
      cyc(); clr();
      mid();
      check("pop16_after_strb", 32'(strb()), 32'h0);
      cyc();

      // Non-stack store: Rsrc address, Rdst data
      bus.mem_write_in = 1'b1; bus.mem_addr_src_in = 1'b1; bus.Rsrc_val_in = 16'h0010;
      bus.mem_data_src_in = 1'b1; bus.Rdst_val_in = 16'hBEEF;
      mid();
      check("st_strb", 32'(strb()), 32'(6'b100000));
      check("st_addr", 32'(bus.mem_addr_out), 32'h010);
      check("st_wdata", 32'(bus.mem_wdata_out), 32'hBEEF);
      check("st_sp", 32'(bus.SP_out), 32'd2046);
      cyc(); clr();

      // Non-stack load: ALU address truncated to 11 bits
      bus.mem_read_in = 1'b1; bus.alu_result_in = 16'hF810;
      mid();
      check("ld_strb", 32'(strb()), 32'(6'b011000));
      check("ld_addr", 32'(bus.mem_addr_out), 32'h010);
      cyc();
      mid();
      check("ld_wait_strb", 32'(strb()), 32'(6'b000100));
      check("ld_data", 32'(bus.load_data_out), 32'hBEEF);
      cyc(); clr();

      // Write and read together with reserved SP_src: plain store
      bus.mem_write_in = 1'b1; bus.mem_read_in = 1'b1; bus.SP_src_in = 2'b11;
      bus.alu_result_in = 16'h0020; bus.Rsrc_val_in = 16'h5555;
      mid();
      check("wr_rd_strb", 32'(strb()), 32'(6'b100000));
      check("wr_rd_addr", 32'(bus.mem_addr_out), 32'h020);
      check("wr_rd_wdata", 32'(bus.mem_wdata_out), 32'h5555);
      cyc(); clr();
      mid();
      check("wr_rd_sp", 32'(bus.SP_out), 32'd2046);
      cyc();

      // 32-bit push with flags
      bus.mem_write_in = 1'b1; bus.SP_src_in = 2'b01; bus.mem_type_in = 1'b1;
      bus.PC_push_pop_in = 1'b1; bus.flags_push_pop_in = 1'b1; bus.PC_in = 32'hA0001F00;
      mid();
      check("push32_hi_strb", 32'(strb()), 32'(6'b101000));
      check("push32_hi_addr", 32'(bus.mem_addr_out), 32'd2046);
      check("push32_hi_wdata", 32'(bus.mem_wdata_out), 32'hA000);
      cyc();
      mid();
      check("push32_lo_strb", 32'(strb()), 32'(6'b100000));
      check("push32_lo_addr", 32'(bus.mem_addr_out), 32'd2045);
      check("push32_lo_wdata", 32'(bus.mem_wdata_out), 32'h1F00);
      cyc(); clr();
      mid();
      check("push32_sp", 32'(bus.SP_out), 32'd2044);
      check("push32_mem_hi", 32'(tb_mem[2046]), 32'hA000);
      check("push32_mem_lo", 32'(tb_mem[2045]), 32'h1F00);
      check("push32_after_strb", 32'(strb()), 32'h0);
      cyc();

      // 32-bit pop with flags
      bus.mem_read_in = 1'b1; bus.SP_src_in = 2'b10; bus.mem_type_in = 1'b1;
      bus.PC_push_pop_in = 1'b1; bus.flags_push_pop_in = 1'b1;
      mid();
      check("pop32_c1_strb", 32'(strb()), 32'(6'b011000));
      check("pop32_c1_addr", 32'(bus.mem_addr_out), 32'd2045);
      cyc();
      mid();
      check("pop32_c2_strb", 32'(strb()), 32'(6'b011000));
      check("pop32_c2_addr", 32'(bus.mem_addr_out), 32'd2046);
      cyc();
      mid();
      check("pop32_c3_strb", 32'(strb()), 32'(6'b000011));
      check("pop32_pc", bus.pc_pop_out, 32'h00001F00);
      check("pop32_flags", 32'(bus.POP_flags_val_out), 32'h5);
      cyc(); clr();
      mid();
      check("pop32_sp", 32'(bus.SP_out), 32'd2046);
      check("pop32_after_strb", 32'(strb()), 32'h0);
      cyc();

      // 32-bit push without flags: high word keeps only PC[28:16]
      bus.mem_write_in = 1'b1; bus.SP_src_in = 2'b01; bus.mem_type_in = 1'b1;
      bus.PC_push_pop_in = 1'b1; bus.PC_in = 32'hE0012345;
      mid();
      check("push32nf_hi_wdata", 32'(bus.mem_wdata_out), 32'h0001);
      cyc();
      mid();
      check("push32nf_lo_wdata", 32'(bus.mem_wdata_out), 32'h2345);
      cyc(); clr();
      mid();
      check("push32nf_sp", 32'(bus.SP_out), 32'd2044);
      cyc();

      // 32-bit pop aborted by reset in POP2
      bus.mem_read_in = 1'b1; bus.SP_src_in = 2'b10; bus.mem_type_in = 1'b1;
      bus.PC_push_pop_in = 1'b1;
      mid();
      check("abort_c1_addr", 32'(bus.mem_addr_out), 32'd2045);
      cyc();
      reset = 1'b1;
      mid();
      check("abort_rst_strb", 32'(strb()), 32'h0);
      cyc();
      reset = 1'b0; clr();
      mid();
      check("abort_after_strb", 32'(strb()), 32'h0);
      check("abort_sp", 32'(bus.SP_out), 32'd2046);
      cyc();
      mid();
      check("abort_late_strb", 32'(strb()), 32'h0);
      check("abort_mem_hi", 32'(tb_mem[2046]), 32'h0001);
      cyc();

      // Pop at SP_RESET boundary
      bus.mem_read_in = 1'b1; bus.SP_src_in = 2'b10;
`ifdef STACK_BOUNDS_CHECK_EN
      mid();
      check("bnd_pop_strb", 32'(strb()), 32'h0);
      cyc(); clr();
      mid();
      check("bnd_err_set", 32'(bus.stack_err_out), 32'h1);
      check("bnd_sp", 32'(bus.SP_out), 32'd2046);
      check("bnd_after_strb", 32'(strb()), 32'h0);
      cyc();
      mid();
      check("bnd_err_sticky", 32'(bus.stack_err_out), 32'h1);
      cyc();
`else
      mid();
      check("wrap_pop_strb", 32'(strb()), 32'(6'b011000));
      check("wrap_pop_addr", 32'(bus.mem_addr_out), 32'd2047);
      cyc();
      mid();
      check("wrap_pop_wait", 32'(strb()), 32'(6'b000100));
      check("wrap_pop_sp", 32'(bus.SP_out), 32'd2047);
      cyc(); clr();
      // Pop at all-ones reads address 0 and wraps SP to 0
      bus.mem_read_in = 1'b1; bus.SP_src_in = 2'b10;
      mid();
      check("wrap0_addr", 32'(bus.mem_addr_out), 32'd0);
      cyc();
      mid();
      check("wrap0_sp", 32'(bus.SP_out), 32'd0);
      cyc(); clr();
      // Push at SP = 0 writes address 0 and wraps to all-ones
      bus.mem_write_in = 1'b1; bus.SP_src_in = 2'b01; bus.Rsrc_val_in = 16'h0A0A;
      mid();
      check("wrapp_strb", 32'(strb()), 32'(6'b100000));
      check("wrapp_addr", 32'(bus.mem_addr_out), 32'd0);
      cyc(); clr();
      mid();
      check("wrapp_sp", 32'(bus.SP_out), 32'd2047);
      check("wrapp_mem", 32'(tb_mem[0]), 32'h0A0A);
      cyc();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
